pcm_rom_router: RTL

PCM_ROM_ROUTER -- requirements
Module: pcm_rom_router

---
 rtl/pcm_route_pkg.sv | 18 +
 rtl/pcm_route_cache.sv | 40 ++++
 rtl/pcm_rom_router.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pcm_route_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_route_pkg
//  Description : Shared state encoding and data width for the PCM ROM router.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcm_route_pkg;

    localparam int c_data_w = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pcm_route_cache.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_route_cache
//  Description : One-entry tag/data cache with combinational lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcm_route_cache
    import pcm_route_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic                CLK,
    input  logic                invalidate,
    input  logic [AW-1:0]       lookup_addr,
    output logic                hit,
    output logic [c_data_w-1:0] hit_data,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [c_data_w-1:0] wr_data
);

    logic                r_valid;
    logic [AW-1:0]       r_tag;
    logic [c_data_w-1:0] r_data;

    always_ff @(posedge CLK) begin
        if (invalidate) begin
            r_valid <= 1'b0;
        end else if (wr_en) begin
            r_valid <= 1'b1;
            r_tag   <= wr_addr;
            r_data  <= wr_data;
        end
    end

    assign hit      = r_valid && (r_tag == lookup_addr);
    assign hit_data = r_data;

endmodule
`default_nettype wire

// File: rtl/pcm_rom_router.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_rom_router
//  Description : Routes byte reads to SDRAM PCM bank slots with a one-entry
//                cache. Optional macro PCMROUTE_TIMEOUT_EN adds a WAIT timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcm_rom_router
    import pcm_route_pkg::*;
#(
    parameter int NBANKS  = 3,
    parameter int BANK_AW = 22,
    parameter int AW      = 24,
    parameter int TIMEOUT = 255
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      REQ_RD,
    input  logic [AW-1:0]             REQ_ADDR,
    output logic [c_data_w-1:0]       REQ_DOUT,
    output logic                      REQ_VALID,
    output logic                      BUSY,
    output logic [NBANKS-1:0]         BANK_CS,
    output logic [NBANKS*BANK_AW-1:0] BANK_ADDR,
    input  logic [NBANKS-1:0]         BANK_OK,
    input  logic [NBANKS*c_data_w-1:0] BANK_DOUT,
    output logic                      TIMEOUT_ERR
);

    localparam int c_iw = AW - BANK_AW;

    state_t                    r_state;
    logic [AW-1:0]             r_addr;
    logic                      r_first;
    logic [NBANKS-1:0]         r_cs;
    logic [NBANKS*BANK_AW-1:0] r_bank_addr;
    logic [c_data_w-1:0]       r_dout;
    logic                      r_valid;
    logic                      r_busy;

    logic [c_iw-1:0]           w_req_idx;
    logic [BANK_AW-1:0]        w_req_off;
    logic                      w_in_range;
    logic [NBANKS-1:0]         w_cs_next;
    logic                      w_sel_ok;
    logic [c_data_w-1:0]       w_sel_data;
    logic                      w_bank_done;
    logic                      w_expired;
    logic                      w_hit;
    logic [c_data_w-1:0]       w_hit_data;

    assign w_req_idx  = REQ_ADDR[AW-1:BANK_AW];
    assign w_req_off  = REQ_ADDR[BANK_AW-1:0];
    assign w_in_range = (int'(w_req_idx) < NBANKS);

    // r_cs is one-hot during WAIT, so it doubles as the bank select mask
    always_comb begin
        w_cs_next  = '0;
        w_sel_data = '0;
        for (int k = 0; k < NBANKS; k++) begin
            if (int'(w_req_idx) == k)
                w_cs_next[k] = 1'b1;
            if (r_cs[k])
                w_sel_data = w_sel_data | BANK_DOUT[k*c_data_w +: c_data_w];
        end
    end

    assign w_sel_ok    = |(BANK_OK & r_cs);
    assign w_bank_done = (r_state == WAIT) && !r_first && w_sel_ok;

    pcm_route_cache #(
        .AW (AW)
    ) u_cache (
        .CLK         (CLK),
        .invalidate  (RESET),
        .lookup_addr (REQ_ADDR),
        .hit         (w_hit),
        .hit_data    (w_hit_data),
        .wr_en       (w_bank_done),
        .wr_addr     (r_addr),
        .wr_data     (w_sel_data)
    );

`ifdef PCMROUTE_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_timeout_err;

    assign w_expired   = (r_state == WAIT) && !w_bank_done &&
                         (int'(r_wait_cnt) == TIMEOUT - 1);
    assign TIMEOUT_ERR = r_timeout_err;
`else
    assign w_expired   = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_first     <= 1'b0;
            r_cs        <= '0;
            r_bank_addr <= '0;
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
`ifdef PCMROUTE_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (REQ_RD) begin
                        r_addr <= REQ_ADDR;
                        r_busy <= 1'b1;
                        if (w_hit) begin
                            r_state <= RESP;
                            r_dout  <= w_hit_data;
                            r_valid <= 1'b1;
                        end else if (!w_in_range) begin
                            r_state <= RESP;
                            r_dout  <= '0;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_first <= 1'b1;
                            r_cs    <= w_cs_next;
                            for (int k = 0; k < NBANKS; k++) begin
                                if (w_cs_next[k])
                                    r_bank_addr[k*BANK_AW +: BANK_AW] <= w_req_off;
                            end
`ifdef PCMROUTE_TIMEOUT_EN
                            r_wait_cnt <= '0;
`endif
                        end
                    end
                end
                WAIT: begin
                    r_first <= 1'b0;
`ifdef PCMROUTE_TIMEOUT_EN
                    r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
                    if (w_bank_done) begin
                        r_state <= RESP;
                        r_dout  <= w_sel_data;
                        r_valid <= 1'b1;
                        r_cs    <= '0;
                    end else if (w_expired) begin
                        r_state <= RESP;
                        r_dout  <= '0;
                        r_valid <= 1'b1;
                        r_cs    <= '0;
`ifdef PCMROUTE_TIMEOUT_EN
                        r_timeout_err <= 1'b1;
`endif
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cs    <= '0;
                end
            endcase
        end
    end

    assign REQ_DOUT  = r_dout;
    assign REQ_VALID = r_valid;
    assign BUSY      = r_busy;
    assign BANK_CS   = r_cs;
    assign BANK_ADDR = r_bank_addr;

endmodule
`default_nettype wire
